// File: rtl/key_event_framer.sv
// key_event_framer
//   Queues front-panel key press/release events and serialises each one to
//   uart_tx as a 3-byte ASCII frame: 'P'/'R', '0'..'7', EOL_CHAR.
//
// Ports
//   clk, reset       clock, asynchronous active-low reset
//   pos_tick         one-cycle press strobe
//   neg_tick         one-cycle release strobe (press wins if both are high)
//   kcode[2:0]       key code, valid with either tick
//   tx_done          uart_tx byte-complete pulse
//   din_rdy          one-cycle load strobe to uart_tx
//   din_byte[7:0]    byte to transmit, held from din_rdy until tx_done
//   busy             FSM not IDLE
//   fifo_count       events queued (the event being sent is not counted)
//   overflow         sticky; an event was dropped because the FIFO was full
module key_event_framer #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [7:0]  EOL_CHAR   = 8'h0D
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pos_tick,
  input  logic                  neg_tick,
  input  logic [2:0]            kcode,
  input  logic                  tx_done,
  output logic                  din_rdy,
  output logic [7:0]            din_byte,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef struct packed {
    logic       press;
    logic [2:0] code;
  } key_ev_t;

  typedef enum logic [2:0] {
    IDLE, SEND_TYPE, WAIT_TYPE, SEND_CODE, WAIT_CODE, SEND_EOL, WAIT_EOL
  } state_t;

  state_t                 state, state_nxt;
  key_ev_t                mem [DEPTH];
  key_ev_t                wr_ev, ev_q;
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic                   wr_req, wr_en, rd_en, full;
  logic [7:0]             type_byte, code_byte;

  // Press has priority, so a simultaneous press/release is one event.
  assign wr_req = pos_tick | neg_tick;
  assign wr_ev  = {pos_tick, kcode};
  assign full   = (fifo_count == DEPTH_CNT);
  // Only IDLE pops, so a read implies the FIFO is non-empty.
  assign rd_en  = (state == IDLE) && (fifo_count != '0);
  // When full, a write is still accepted if the head leaves the same cycle.
  assign wr_en  = wr_req && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_ev;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      ev_q       <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        ev_q   <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (wr_req && !wr_en) overflow <= 1'b1;
    end
  end

  assign type_byte = ev_q.press ? 8'h50 : 8'h52;
  assign code_byte = 8'h30 + {5'b0, ev_q.code};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    din_rdy   = 1'b0;
    din_byte  = 8'h00;
    case (state)
      IDLE:      if (rd_en) state_nxt = SEND_TYPE;
      SEND_TYPE: begin din_rdy = 1'b1; din_byte = type_byte; state_nxt = WAIT_TYPE; end
      WAIT_TYPE: begin din_byte = type_byte; if (tx_done) state_nxt = SEND_CODE; end
      SEND_CODE: begin din_rdy = 1'b1; din_byte = code_byte; state_nxt = WAIT_CODE; end
      WAIT_CODE: begin din_byte = code_byte; if (tx_done) state_nxt = SEND_EOL; end
      SEND_EOL:  begin din_rdy = 1'b1; din_byte = EOL_CHAR;  state_nxt = WAIT_EOL; end
      WAIT_EOL:  begin din_byte = EOL_CHAR;  if (tx_done) state_nxt = IDLE; end
      default:   state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
